// File: rtl/gray_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : gray_ctrl_pkg
// Brief   : Shared op encodings, FSM state type and Gray conversion helper
//           for the Gray-code sequencer.
// Revision: 1.0 - initial release
// ============================================================================
package gray_ctrl_pkg;

    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_LOAD = 2'b01;
    localparam logic [1:0] OP_UP   = 2'b10;
    localparam logic [1:0] OP_DOWN = 2'b11;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Operates on a 32-bit container; callers cast to their own width.
    function automatic logic [31:0] bin2gray(input logic [31:0] bin);
        return bin ^ (bin >> 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/gray_updown_cntr.sv
`default_nettype none
// ============================================================================
// Module  : gray_updown_cntr
// Brief   : Registered up/down binary counter with same-edge Gray output and
//           a registered wrap pulse.
// Revision: 1.0 - initial release
// ============================================================================
module gray_updown_cntr
    import gray_ctrl_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             dir,
    output logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray,
    output logic             wrap
);

    logic [WIDTH-1:0] bin_d,  bin_q;
    logic [WIDTH-1:0] gray_d, gray_q;
    logic             wrap_d, wrap_q;

    // Gray is derived from the next binary value so both registers move together.
    always_comb begin
        bin_d  = bin_q;
        wrap_d = 1'b0;
        if (load) begin
            bin_d = load_val;
        end else if (en) begin
            if (dir) begin
                bin_d  = bin_q + WIDTH'(1);
                wrap_d = (bin_q == {WIDTH{1'b1}});
            end else begin
                bin_d  = bin_q - WIDTH'(1);
                wrap_d = (bin_q == '0);
            end
        end
        gray_d = WIDTH'(bin2gray(32'(bin_d)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bin_q  <= '0;
            gray_q <= '0;
            wrap_q <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            gray_q <= gray_d;
            wrap_q <= wrap_d;
        end
    end

    assign bin  = bin_q;
    assign gray = gray_q;
    assign wrap = wrap_q;

endmodule
`default_nettype wire

// File: rtl/gray_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : gray_seq_ctrl
// Brief   : Command-driven sequencer (LOAD / UP n / DOWN n) around an up/down
//           Gray-code counter, with done and wrap pulses.
// Revision: 1.0 - initial release
// ============================================================================
module gray_seq_ctrl
    import gray_ctrl_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_arg,
    input  logic             pause,
    output logic [WIDTH-1:0] bin_value,
    output logic [WIDTH-1:0] gray_value,
    output logic             busy,
    output logic             done,
    output logic             wrap
);

    state_t           state_d, state_q;
    logic [CNT_W-1:0] remaining_d, remaining_q;
    logic             dir_d, dir_q;
    logic             busy_d, busy_q;
    logic             done_d, done_q;

    logic             w_accept;
    logic             w_load;
    logic             w_en;

    assign cmd_ready = (state_q == ST_IDLE);
    assign w_accept  = cmd_valid & cmd_ready;

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        dir_d       = dir_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        w_load      = 1'b0;
        w_en        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    case (cmd_op)
                        OP_LOAD: begin
                            w_load = 1'b1;
                            done_d = 1'b1;
                        end
                        OP_UP, OP_DOWN: begin
                            dir_d = (cmd_op == OP_UP);
                            if (cmd_arg == '0) begin
                                done_d = 1'b1;
                            end else begin
                                remaining_d = cmd_arg;
                                busy_d      = 1'b1;
                                state_d     = ST_RUN;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            ST_RUN: begin
                // A paused sequence holds everything; the counter's wrap self-clears.
                if (!pause) begin
                    w_en        = 1'b1;
                    remaining_d = remaining_q - CNT_W'(1);
                    if (remaining_q == CNT_W'(1)) begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            dir_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            dir_q       <= dir_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    gray_updown_cntr #(
        .WIDTH (WIDTH)
    ) u_cntr (
        .clk      (clk),
        .rst      (rst),
        .load     (w_load),
        .load_val (cmd_arg[WIDTH-1:0]),
        .en       (w_en),
        .dir      (dir_q),
        .bin      (bin_value),
        .gray     (gray_value),
        .wrap     (wrap)
    );

    assign busy = busy_q;
    assign done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_gray_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_gray_seq_ctrl
// Brief   : Directed self-checking bench for gray_seq_ctrl (WIDTH=4, CNT_W=8).
// Revision: 1.0 - initial release
// ============================================================================
module tb_gray_seq_ctrl;

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_arg;
    logic       pause;
    logic [3:0] bin_value;
    logic [3:0] gray_value;
    logic       busy;
    logic       done;
    logic       wrap;

    int n_checks = 0;
    int n_fail   = 0;

    gray_seq_ctrl #(
        .WIDTH (4),
        .CNT_W (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_arg    (cmd_arg),
        .pause      (pause),
        .bin_value  (bin_value),
        .gray_value (gray_value),
        .busy       (busy),
        .done       (done),
        .wrap       (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge, then sample 1 time unit later and check the Gray invariant.
    task automatic tick();
        logic [3:0] b;
        @(posedge clk);
        #1;
        b = bin_value;
        check("gray_inv", int'(gray_value), int'(b ^ (b >> 1)));
    endtask

    task automatic send(input logic [1:0] op, input logic [7:0] arg);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_arg   = arg;
        tick();
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_arg   = 8'h00;
    endtask

    task automatic expect_st(input string tag, input int b, input int g,
                             input int bz, input int dn, input int wr);
        check({tag, "_bin"},  int'(bin_value),  b);
        check({tag, "_gray"}, int'(gray_value), g);
        check({tag, "_busy"}, int'(busy),       bz);
        check({tag, "_done"}, int'(done),       dn);
        check({tag, "_wrap"}, int'(wrap),       wr);
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_arg   = 8'h00;
        pause     = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // 1. reset state and LOAD 0x0A
        expect_st("rst", 0, 0, 0, 0, 0);
        check("rst_ready", int'(cmd_ready), 1);
        send(2'b01, 8'h0A);
        expect_st("ld0a", 4'hA, 4'hF, 0, 1, 0);
        tick();
        check("ld0a_done_clr", int'(done), 0);

        // 2. LOAD 0xE then UP 3 across the wrap
        send(2'b01, 8'hFE);               // upper arg bits must be ignored
        expect_st("ld0e", 4'hE, 4'h9, 0, 1, 0);
        send(2'b10, 8'd3);
        expect_st("up3_e0", 4'hE, 4'h9, 1, 0, 0);
        check("up3_ready", int'(cmd_ready), 0);
        tick(); expect_st("up3_e1", 4'hF, 4'h8, 1, 0, 0);
        tick(); expect_st("up3_e2", 4'h0, 4'h0, 1, 0, 1);
        tick(); expect_st("up3_e3", 4'h1, 4'h1, 0, 1, 0);
        check("up3_ready_back", int'(cmd_ready), 1);
        tick(); expect_st("up3_after", 4'h1, 4'h1, 0, 0, 0);

        // 3. LOAD 0 then DOWN 2, then back-to-back UP 1 in the done cycle
        send(2'b01, 8'h00);
        send(2'b11, 8'd2);
        expect_st("dn2_e0", 4'h0, 4'h0, 1, 0, 0);
        tick(); expect_st("dn2_e1", 4'hF, 4'h8, 1, 0, 1);
        tick(); expect_st("dn2_e2", 4'hE, 4'h9, 0, 1, 0);
        send(2'b10, 8'd1);
        expect_st("b2b_e0", 4'hE, 4'h9, 1, 0, 0);
        tick(); expect_st("b2b_e1", 4'hF, 4'h8, 0, 1, 0);

        // 4. UP 5 from 0xF with a 3-cycle pause after the first step
        send(2'b10, 8'd5);
        tick(); expect_st("up5_e1", 4'h0, 4'h0, 1, 0, 1);
        pause = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_st("up5_pause", 4'h0, 4'h0, 1, 0, 0);
            check("up5_pause_ready", int'(cmd_ready), 0);
        end
        pause = 1'b0;
        tick(); expect_st("up5_s2", 4'h1, 4'h1, 1, 0, 0);
        tick(); expect_st("up5_s3", 4'h2, 4'h3, 1, 0, 0);
        tick(); expect_st("up5_s4", 4'h3, 4'h2, 1, 0, 0);
        tick(); expect_st("up5_s5", 4'h4, 4'h6, 0, 1, 0);

        // 5. UP 0 and NOP
        send(2'b10, 8'd0);
        expect_st("up0", 4'h4, 4'h6, 0, 1, 0);
        tick(); expect_st("up0_after", 4'h4, 4'h6, 0, 0, 0);
        send(2'b00, 8'h09);
        expect_st("nop", 4'h4, 4'h6, 0, 0, 0);

        // 6. reset mid-run of UP 10; a held LOAD waits for cmd_ready
        send(2'b10, 8'd10);
        tick(); tick();
        expect_st("up10_e2", 4'h6, 4'h5, 1, 0, 0);
        cmd_valid = 1'b1;
        cmd_op    = 2'b01;
        cmd_arg   = 8'h07;
        tick(); expect_st("up10_held", 4'h7, 4'h4, 1, 0, 0);
        tick(); expect_st("up10_held2", 4'h8, 4'hC, 1, 0, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        expect_st("mid_rst", 0, 0, 0, 0, 0);
        check("mid_rst_ready", int'(cmd_ready), 1);
        tick(); expect_st("held_ld", 4'h7, 4'h4, 0, 1, 0);
        cmd_valid = 1'b0;
        tick(); expect_st("held_ld_after", 4'h7, 4'h4, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1);
    end

endmodule
`default_nettype wire
